// File: rtl/spu_fetch_pkg.sv
// rtl/spu_fetch_pkg.sv - shared fetch/decode types and constants
//
// Purpose: widths, the NOP encoding and the fetched-pair record shared by the
//          instruction buffer and its storage array.
// Contents:
//   bitsize      PC width, matches fetch
//   INSTR_W      width of one instruction
//   NOP_INSTR    value driven on empty instruction slots
//   fetch_pair_t {instr1, instr2, pc}, instr1 is the older instruction
package spu_fetch_pkg;

  localparam int bitsize = 11;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [INSTR_W-1:0] instr1;
    logic [INSTR_W-1:0] instr2;
    logic [bitsize-1:0] pc;
  } fetch_pair_t;

endpackage

// File: rtl/pair_queue_ram.sv
// rtl/pair_queue_ram.sv - DEPTH x fetch_pair_t register array
//
// Purpose: storage for the instruction buffer. One synchronous write port and
//          one asynchronous read port. Contents are not reset; occupancy is
//          tracked by the owner, so stale entries are never presented.
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable
//   waddr  in   write entry index
//   wdata  in   pair written at waddr
//   raddr  in   read entry index
//   rdata  out  pair stored at raddr (combinational)
module pair_queue_ram
  import spu_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fetch_pair_t   wdata,
  input  logic [AW-1:0] raddr,
  output fetch_pair_t   rdata
);

  fetch_pair_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_buffer.sv
// rtl/instruction_buffer.sv - dual-issue instruction queue between fetch and decode
//
// Purpose: accepts one instruction pair plus PC per cycle from fetch, presents
//          the oldest pending instruction(s) to decode, and lets decode take
//          0, 1 or 2 instructions per cycle. A pair split across two issue
//          cycles is tracked by the half flag. Flush empties the queue.
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   in_valid     in   fetch presents a pair
//   in_instr1    in   older instruction of the fetched pair
//   in_instr2    in   younger instruction of the fetched pair
//   in_pc        in   PC of the fetched pair
//   in_ready     out  a pair can be accepted (drives fetch PC enable)
//   flush        in   discard all entries; same-cycle push/consume ignored
//   issue_count  in   instructions decode takes this cycle (3 acts as 2)
//   out_instr1   out  oldest pending instruction
//   out_instr2   out  next pending instruction of the same pair
//   out_valid1   out  out_instr1 valid
//   out_valid2   out  out_instr2 valid
//   out_pc       out  PC of the head pair
//   out_half     out  head pair's first slot already issued
module instruction_buffer
  import spu_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr1,
  input  logic [INSTR_W-1:0] in_instr2,
  input  logic [bitsize-1:0] in_pc,
  output logic               in_ready,
  input  logic               flush,
  input  logic [1:0]         issue_count,
  output logic [INSTR_W-1:0] out_instr1,
  output logic [INSTR_W-1:0] out_instr2,
  output logic               out_valid1,
  output logic               out_valid2,
  output logic [bitsize-1:0] out_pc,
  output logic               out_half
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          half;

  fetch_pair_t   wdata;
  fetch_pair_t   head;

  logic          empty;
  logic          push;
  logic          pop;
  logic          half_next;
  logic [1:0]    req_count;
  logic [1:0]    slots;
  logic [1:0]    eff_count;

  // Ready looks only at the registered count: a full buffer stays closed
  // even if decode frees an entry in the same cycle.
  assign in_ready = (count < FULL_COUNT);
  assign empty    = (count == '0);

  assign req_count = (issue_count == 2'd3) ? 2'd2 : issue_count;

  always_comb begin
    slots = 2'd2;
    if (empty) begin
      slots = 2'd0;
    end else if (half) begin
      slots = 2'd1;
    end
  end

  // Decode can never take more than what is shown this cycle.
  assign eff_count = (req_count < slots) ? req_count : slots;

  assign push = in_valid && in_ready && !flush;
  assign pop  = !flush && ((eff_count == 2'd2) || ((eff_count == 2'd1) && half));

  // Single issue toggles half: the first takes slot1, the second retires the
  // pair. Dual issue only happens with half=0 and leaves it at 0.
  always_comb begin
    half_next = half;
    if (flush) begin
      half_next = 1'b0;
    end else if (eff_count == 2'd1) begin
      half_next = !half;
    end
  end

  assign wdata = '{instr1: in_instr1, instr2: in_instr2, pc: in_pc};

  pair_queue_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      half   <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      half   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
      half  <= half_next;
    end
  end

  // Outputs come straight from registered state, so an async reset clears
  // them without waiting for a clock edge.
  always_comb begin
    out_instr1 = NOP_INSTR;
    out_instr2 = NOP_INSTR;
    out_valid1 = 1'b0;
    out_valid2 = 1'b0;
    out_pc     = '0;
    out_half   = 1'b0;
    if (!empty) begin
      out_valid1 = 1'b1;
      out_pc     = head.pc;
      out_half   = half;
      if (half) begin
        out_instr1 = head.instr2;
      end else begin
        out_instr1 = head.instr1;
        out_instr2 = head.instr2;
        out_valid2 = 1'b1;
      end
    end
  end

endmodule
